axi4_stream_fifo: RTL

AXI4_STREAM_FIFO -- requirements
Module: axi4_stream_fifo

---
 rtl/axi4_stream_fifo_pkg.sv | 33 +++
 rtl/axi4_stream_if.sv | 29 ++
 rtl/axi4_stream_fifo_ram.sv | 22 ++
 rtl/axi4_stream_fifo.sv | 135 +++++++++++++
 4 files changed

// File: rtl/axi4_stream_fifo_pkg.sv
// Shared beat layout and width helpers for the AXI4-Stream FIFO.
package axi4_stream_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 1;
  localparam int DEF_DEST_W = 1;
  localparam int DEF_USER_W = 1;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int beat_w(
    input int dw,
    input int iw,
    input int ddw,
    input int uw
  );
    return dw + 2 * strb_w(dw) + iw + ddw + uw + 1;
  endfunction

  // Reference beat at the default widths; field order matches the RAM word.
  typedef struct packed {
    logic                         tlast;
    logic [DEF_USER_W-1:0]        tuser;
    logic [DEF_DEST_W-1:0]        tdest;
    logic [DEF_ID_W-1:0]          tid;
    logic [DEF_DATA_W/8-1:0]      tkeep;
    logic [DEF_DATA_W/8-1:0]      tstrb;
    logic [DEF_DATA_W-1:0]        tdata;
  } beat_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tlast;

  modport master (
    output tvalid, tdata, tstrb, tkeep,
    output tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep,
    input  tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/axi4_stream_fifo_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
module axi4_stream_fifo_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  // rd_data holds its value when rd_en is low; it acts as a pipeline stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axi4_stream_fifo.sv
// AXI4-Stream FIFO: RAM -> read stage -> output register, optional packet mode.
module axi4_stream_fifo
  import axi4_stream_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 16,
  parameter int PKT_MODE    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  axi4_stream_if.slave           pkt_i,
  axi4_stream_if.master          pkt_o,
  output logic [$clog2(DEPTH):0] used_words_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = strb_w(TDATA_WIDTH);
  localparam int BW = beat_w(TDATA_WIDTH, TID_WIDTH,
                             TDEST_WIDTH, TUSER_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;
    logic [SW-1:0]          tkeep;
    logic [SW-1:0]          tstrb;
    logic [TDATA_WIDTH-1:0] tdata;
  } word_t;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    used_q, ram_cnt_q;
  logic [CW-1:0]    pkt_cnt_q, rd_pkts_q;
  logic [DEPTH-1:0] last_q;
  logic             mid_q, out_valid_q, force_q;
  word_t            wr_word, rd_word, out_q;

  logic accept, out_hs, mid_move, gate;
  logic rd_issue, rd_last, in_last, out_last;
  logic force_set;

  assign full_o       = (used_q == FULL_CNT);
  assign empty_o      = (used_q == '0);
  assign used_words_o = used_q;

  assign pkt_i.tready = rst_n_i && !full_o;
  assign accept       = pkt_i.tvalid && pkt_i.tready;
  assign out_hs       = out_valid_q && pkt_o.tready;
  assign mid_move     = mid_q && (!out_valid_q || pkt_o.tready);

  // Packet mode: read only from a packet whose tlast is already in RAM,
  // unless a full FIFO holding no complete packet forces cut-through.
  assign gate = (PKT_MODE == 0) || (rd_pkts_q != '0) || force_q;
  assign rd_issue = (ram_cnt_q != '0) && gate &&
                    (!mid_q || mid_move);
  assign rd_last   = rd_issue && last_q[rd_ptr];
  assign in_last   = accept && pkt_i.tlast;
  assign out_last  = out_hs && out_q.tlast;
  assign force_set = (PKT_MODE != 0) && full_o &&
                     (pkt_cnt_q == '0);

  assign wr_word = '{
    tlast: pkt_i.tlast,
    tuser: pkt_i.tuser,
    tdest: pkt_i.tdest,
    tid:   pkt_i.tid,
    tkeep: pkt_i.tkeep,
    tstrb: pkt_i.tstrb,
    tdata: pkt_i.tdata
  };

  axi4_stream_fifo_ram #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      used_q      <= '0;
      ram_cnt_q   <= '0;
      pkt_cnt_q   <= '0;
      rd_pkts_q   <= '0;
      last_q      <= '0;
      mid_q       <= 1'b0;
      out_valid_q <= 1'b0;
      force_q     <= 1'b0;
      out_q       <= '0;
    end else begin
      if (accept) begin
        wr_ptr         <= wr_ptr + AW'(1);
        last_q[wr_ptr] <= pkt_i.tlast;
      end
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      used_q    <= used_q + CW'(accept) - CW'(out_hs);
      ram_cnt_q <= ram_cnt_q + CW'(accept) - CW'(rd_issue);
      pkt_cnt_q <= pkt_cnt_q + CW'(in_last) - CW'(out_last);
      rd_pkts_q <= rd_pkts_q + CW'(in_last) - CW'(rd_last);
      if (rd_last)        force_q <= 1'b0;
      else if (force_set) force_q <= 1'b1;
      if (rd_issue)      mid_q <= 1'b1;
      else if (mid_move) mid_q <= 1'b0;
      if (mid_move) begin
        out_valid_q <= 1'b1;
        out_q       <= rd_word;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign pkt_o.tvalid = out_valid_q;
  assign pkt_o.tdata  = out_q.tdata;
  assign pkt_o.tstrb  = out_q.tstrb;
  assign pkt_o.tkeep  = out_q.tkeep;
  assign pkt_o.tid    = out_q.tid;
  assign pkt_o.tdest  = out_q.tdest;
  assign pkt_o.tuser  = out_q.tuser;
  assign pkt_o.tlast  = out_q.tlast;
endmodule
